hub75_driver: RTL
=================

# hub75_driver

Transmit side of the HUB75 panel link. Scans a 1/8-scan, two-half panel (16 rows × COLS columns) out of a pixel framebuffer using binary-coded modulation (one bit plane per latch). It drives shift clock, latch, output enable, row address and the six colour lines. It is the block that feeds the panel pins of CubeTop, in the same format the panel model in the bench reconstructs into `led_values`.

## Interface
- `COLS`, 64: columns per row (shift-register length).
- `ROWS_HALF`, 8: rows per half; the row address is $clog2(ROWS_HALF) bits wide.
- `BPC`, 8: bits per colour channel, which is also the number of bit planes.
- `ON_BASE`, 16: oe_-low cycles for bit plane 0. Plane p is displayed for ON_BASE<<p cycles.
- `AW`, $clog2(COLS*ROWS_HALF*2): framebuffer address width.

Ports:
- `clk25`, in, 1: sole clock.
- `reset_`, in, 1: asynchronous, active-low reset.
- `rd_req`, out, 1: framebuffer read strobe.
- `rd_addr`, out, AW: pixel address, equal to row*COLS + col.
- `rd_data`, in, 3*BPC: pixel word {b, g, r}. Red is in bits [BPC-1:0]. The word is valid exactly 1 cycle after `rd_req`.
- `hub75_clk`, out, 1: shift clock. The panel samples on its rising edge.
- `hub75_lat`, out, 1: latch pulse.
- `hub75_oe_`, out, 1: output enable, active low.
- `hub75_row`, out, $clog2(ROWS_HALF): displayed row; row+ROWS_HALF is lit at the same time.
- `hub75_r0`, `hub75_g0`, `hub75_b0`, out, 1 each: colour lines for the upper half (rows 0..ROWS_HALF-1).
- `hub75_r1`, `hub75_g1`, `hub75_b1`, out, 1 each: colour lines for the lower half.
- `frame_start`, out, 1: one-cycle pulse at the start of each frame.

## Operation
States:
- SHIFT → LATCH → DISPLAY, then back to SHIFT.
- The counters are row r (0..ROWS_HALF-1), plane p (0..BPC-1) and column c.

Loop order:
- Each row sends planes p = 0..BPC-1.
- After plane BPC-1, p wraps to 0 and r increments.
- r wraps from ROWS_HALF-1 to 0.

SHIFT state:
- COLS columns are sent in the order c = COLS-1 down to 0, so after the shift the panel's shift-register bit i holds column i.
- Each column takes 4 phases:
  - ph0: `rd_req`=1, `rd_addr`=r*COLS+c.
  - ph1: `rd_req`=1, `rd_addr`=(r+ROWS_HALF)*COLS+c. The upper pixel is captured.
  - ph2: the lower pixel is captured. The colour lines are driven, and `hub75_clk`=0.
  - ph3: `hub75_clk`=1. The colour lines are held.
- Colour-line values:
  - `hub75_r0` = upper[p], `hub75_g0` = upper[BPC+p], `hub75_b0` = upper[2*BPC+p].
  - The `*1` lines take the same bits from the lower pixel.
- `hub75_oe_`=1 throughout SHIFT.
- `rd_req`=0 outside ph0 and ph1.

LATCH state (2 cycles, `hub75_oe_`=1):
- Cycle 0: `hub75_lat`=1. If p==0, `hub75_row` takes the value r.
- Cycle 1: `hub75_lat`=0.

DISPLAY state:
- `hub75_oe_`=0 for exactly ON_BASE<<p cycles.
- Then `hub75_oe_` returns to 1 and the block enters SHIFT for the next plane.

`frame_start`:
- Pulses high on the first SHIFT cycle of r=0, p=0.
- This includes the first cycle after reset is released.

Width rule:
- The display counter is wide enough for ON_BASE<<(BPC-1), which is 2048 at the defaults.
- The counter does not wrap early.

Reset (asynchronous, any time, including mid-SHIFT or mid-DISPLAY):
- All outputs go immediately to their reset values.
- All counters are cleared.
- After release, the block restarts at r=0, p=0, c=COLS-1, phase ph0.

## Timing
Reset values:
- `hub75_clk`=0, `hub75_lat`=0, `hub75_oe_`=1.
- `hub75_row`=0, all colour lines 0.
- `rd_req`=0, `rd_addr`=0, `frame_start`=0.

Latency:
- Read data is consumed exactly 1 cycle after the request.
- There is no backpressure.

Durations at the defaults:
- One SHIFT state: 4*COLS = 256 cycles.
- One plane: 256 + 2 + (16<<p) cycles.
- One row: 8*258 + 16*255 = 6144 cycles.
- One frame: 8*6144 = 49152 cycles.

Signal timing:
- `hub75_clk` is high for one cycle in every 4.
- Colour lines are stable for at least 1 cycle before and during the `hub75_clk` high cycle.
- `hub75_lat` is never high while `hub75_oe_`=0.
- `hub75_row` changes only while `hub75_oe_`=1.

## Test plan
- **Reset values:** assert `reset_`=0 mid-frame → all outputs at their reset values in the same cycle.
  - After release: `frame_start` pulses on cycle 1.
  - The first `rd_addr` values are 63, then 575.
- **Single upper pixel:** framebuffer is all 0 except address 5 = 0x0000FF (row 0, col 5).
  - In each of the 8 planes of row 0, `hub75_r0` is 1 only at the 59th `hub75_clk` rise.
  - All other colour lines stay 0.
  - Panel model reconstructs `led_values[5]` = 0x0000FF.
- **Lower-half routing:** address 8*64+0 = 0xFF0000.
  - `hub75_b1` is 1 on the last (64th) shift clock of every row-0 plane.
  - `hub75_b0` stays 0.
- **Bit-plane selection:** pixel value 0x000005.
  - `hub75_r0` is set for that column in planes 0 and 2 only.
- **Modulation timing:**
  - `hub75_oe_` low runs measure 16, 32, 64, …, 2048 cycles.
  - There are 8 `hub75_lat` pulses per row.
  - The `hub75_row` sequence is 0..7 and then wraps to 0.
  - `frame_start` period is exactly 49152 cycles.
- **Reset mid-operation:** assert reset during the SHIFT of row 3, plane 4.
  - Outputs go to their reset values immediately.
  - After release, the block restarts at row 0, plane 0, and `frame_start` pulses.

Source files
------------

// File: rtl/hub75_driver_if.sv
// hub75_driver_if: framebuffer read port between the HUB75 scanner and pixel memory
//   rd_req  : read strobe, driven by the scanner
//   rd_addr : pixel address row*COLS + col, driven by the scanner
//   rd_data : pixel word {b, g, r}, returned by memory one cycle after rd_req
interface hub75_driver_if #(
    parameter int AW = 10,
    parameter int DW = 24
);
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    modport master (output rd_req, output rd_addr, input rd_data);
    modport slave (input rd_req, input rd_addr, output rd_data);
endinterface

// File: rtl/hub75_driver.sv
// hub75_driver: scans a 1/8-scan two-half HUB75 panel from a framebuffer using binary-coded modulation
//   clk25, reset_         : clock, asynchronous active-low reset
//   fb (master)           : framebuffer read port (rd_req, rd_addr, rd_data)
//   hub75_clk/lat/oe_     : shift clock, latch pulse, active-low output enable
//   hub75_row             : displayed row pair address
//   hub75_{r,g,b}{0,1}    : colour lines for upper (0) and lower (1) halves
//   frame_start           : one-cycle pulse on the first shift cycle of each frame
module hub75_driver #(
    parameter int COLS      = 64,
    parameter int ROWS_HALF = 8,
    parameter int BPC       = 8,
    parameter int ON_BASE   = 16,
    parameter int AW        = $clog2(COLS * ROWS_HALF * 2)
) (
    input  logic                         clk25,
    input  logic                         reset_,
    hub75_driver_if.master               fb,
    output logic                         hub75_clk,
    output logic                         hub75_lat,
    output logic                         hub75_oe_,
    output logic [$clog2(ROWS_HALF)-1:0] hub75_row,
    output logic                         hub75_r0,
    output logic                         hub75_g0,
    output logic                         hub75_b0,
    output logic                         hub75_r1,
    output logic                         hub75_g1,
    output logic                         hub75_b1,
    output logic                         frame_start
);
    localparam int CBW = $clog2(COLS);
    localparam int RW  = $clog2(ROWS_HALF);
    localparam int PW  = $clog2(BPC);
    localparam int CW  = $clog2((ON_BASE << (BPC - 1)) + 1);

    typedef enum logic [1:0] {SHIFT, LATCH, DISPLAY} state_t;

    state_t           st_q, st_d;
    logic             run_q;
    logic [1:0]       ph_q, ph_d;
    logic [CBW-1:0]   c_q, c_d;
    logic [RW-1:0]    r_q, r_d, row_q, row_d;
    logic [PW-1:0]    p_q, p_d;
    logic [CW-1:0]    cnt_q, cnt_d, on_len;
    logic [3*BPC-1:0] up_q, up_d;
    logic [5:0]       col_q, col_d, col_live;
    logic [BPC-1:0]   ur, ug, ub, lr, lg, lb;
    logic [AW-1:0]    up_addr, lo_addr;
    logic             shift_act;

    // run_q holds every output at its reset value until the first edge after release,
    // so the state counters can describe the cycle currently on the pins.
    always_ff @(posedge clk25 or negedge reset_) begin
        if (!reset_) begin
            st_q  <= SHIFT;
            run_q <= 1'b0;
            ph_q  <= '0;
            c_q   <= CBW'(COLS - 1);
            r_q   <= '0;
            p_q   <= '0;
            cnt_q <= '0;
            up_q  <= '0;
            col_q <= '0;
            row_q <= '0;
        end else begin
            st_q  <= st_d;
            run_q <= 1'b1;
            ph_q  <= ph_d;
            c_q   <= c_d;
            r_q   <= r_d;
            p_q   <= p_d;
            cnt_q <= cnt_d;
            up_q  <= up_d;
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign {ub, ug, ur} = up_q;
    assign {lb, lg, lr} = fb.rd_data;
    assign on_len       = CW'(ON_BASE) << p_q;
    // The lower pixel arrives during ph2 and goes straight to the pins; col_q holds it through ph3.
    assign col_live     = {lb[p_q], lg[p_q], lr[p_q], ub[p_q], ug[p_q], ur[p_q]};

    always_comb begin
        st_d  = st_q;
        ph_d  = ph_q;
        c_d   = c_q;
        r_d   = r_q;
        p_d   = p_q;
        cnt_d = cnt_q;
        up_d  = up_q;
        col_d = col_q;
        row_d = row_q;
        if (run_q) begin
            case (st_q)
                SHIFT: begin
                    ph_d  = ph_q + 2'd1;
                    up_d  = ph_q == 2'd1 ? fb.rd_data : up_q;
                    col_d = ph_q == 2'd2 ? col_live : col_q;
                    if (ph_q == 2'd3) begin
                        c_d   = c_q - 1'b1;
                        st_d  = c_q == '0 ? LATCH : SHIFT;
                        cnt_d = '0;
                    end
                end
                LATCH: begin
                    cnt_d = cnt_q + 1'b1;
                    row_d = (cnt_q == '0 && p_q == '0) ? r_q : row_q;
                    if (cnt_q == CW'(1)) begin
                        st_d  = DISPLAY;
                        cnt_d = '0;
                    end
                end
                DISPLAY: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == on_len - CW'(1)) begin
                        st_d  = SHIFT;
                        cnt_d = '0;
                        p_d   = p_q == PW'(BPC - 1) ? '0 : p_q + 1'b1;
                        r_d   = p_q != PW'(BPC - 1) ? r_q : r_q == RW'(ROWS_HALF - 1) ? '0 : r_q + 1'b1;
                    end
                end
                default: st_d = SHIFT;
            endcase
        end
    end

    assign shift_act   = run_q && st_q == SHIFT;
    assign up_addr     = AW'(r_q) * AW'(COLS) + AW'(c_q);
    assign lo_addr     = (AW'(r_q) + AW'(ROWS_HALF)) * AW'(COLS) + AW'(c_q);
    assign fb.rd_req   = shift_act && !ph_q[1];
    assign fb.rd_addr  = !fb.rd_req ? '0 : ph_q[0] ? lo_addr : up_addr;
    assign hub75_clk   = shift_act && ph_q == 2'd3;
    assign hub75_lat   = run_q && st_q == LATCH && cnt_q == '0;
    assign hub75_oe_   = !(run_q && st_q == DISPLAY);
    assign hub75_row   = row_q;
    assign frame_start = shift_act && ph_q == '0 && c_q == CBW'(COLS - 1) && r_q == '0 && p_q == '0;
    assign {hub75_b1, hub75_g1, hub75_r1, hub75_b0, hub75_g0, hub75_r0} =
        (shift_act && ph_q == 2'd2) ? col_live : col_q;
endmodule
